regfile_mp_sb: RTL and testbench

//  Parametrised multi-read, dual-write register file with a per-register busy scoreboard.

---
 rtl/regfile_mp_sb.sv | 111 +++++++++++
 tb/tb_regfile_mp_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with a per-register busy scoreboard.
// Write port 0 is ALU writeback, write port 1 is the late load/multicycle return path.
// Busy bits mark registers with an in-flight producer so decode can stall on RAW hazards.
// Register 0 always reads as zero and is never marked busy.
module regfile_mp_sb #(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    localparam int AW      = $clog2(NREGS),
    parameter  int NRD     = 2,
    parameter  int BYPASS  = 1,
    parameter  int DBG_IDX = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                issue_vld,
    input  logic [AW-1:0]       issue_dst,
    output logic [NREGS-1:0]    busy_vec,
    output logic [XLEN-1:0]     dbg_out
);

    localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Register storage; port 1 is written first so a same-address port 0 write overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we1 && (wa1 != '0)) begin
                regs[wa1] <= wd1;
            end
            if (we0 && (wa0 != '0)) begin
                regs[wa0] <= wd0;
            end
        end
    end

    // Scoreboard next state: a new issue beats a retiring write, register 0 never busy.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_vld && (issue_dst == AW'(i))) begin
                busy_next[i] = 1'b1;
            end else if ((we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)))) begin
                busy_next[i] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; reset clears every outstanding producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;
    assign dbg_out  = regs[DBG_A];

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit0;
        logic            hit1;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = ra[k*AW +: AW];
        // Writes during reset are discarded, so they must not be forwarded either.
        assign hit0 = (BYPASS != 0) && !rst && we0 && (wa0 == addr);
        assign hit1 = (BYPASS != 0) && !rst && we1 && (wa1 == addr);

        // Read mux: forwarded write data (port 0 first), else stored value; r0 reads zero.
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (hit0) begin
                data = wd0;
                bsy  = 1'b0;
            end else if (hit1) begin
                data = wd1;
                bsy  = 1'b0;
            end
            if (addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd[k*XLEN +: XLEN] = data;
        assign rd_busy[k]         = bsy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: drives a forwarding and a non-forwarding register file with the same
// stimulus and checks both against an array-based model of the register file behaviour.
module tb_regfile_mp_sb;

    localparam int XLEN    = 32;
    localparam int NREGS   = 16;
    localparam int AW      = 4;
    localparam int NRD     = 3;
    localparam int DBG_IDX = 5;
    localparam int NRAND   = 10000;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                issue_vld;
    logic [AW-1:0]       issue_dst;

    logic [NRD*XLEN-1:0] rd_bp, rd_nb;
    logic [NRD-1:0]      rdb_bp, rdb_nb;
    logic [NREGS-1:0]    bv_bp, bv_nb;
    logic [XLEN-1:0]     dbg_bp, dbg_nb;

    int checks = 0;
    int errors = 0;

    // Model state: plain array of register values and one busy flag per register
    logic [XLEN-1:0]  mMem [NREGS];
    logic [NREGS-1:0] mBusy;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .DBG_IDX(DBG_IDX)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_bp), .rd_busy(rdb_bp),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .issue_vld(issue_vld), .issue_dst(issue_dst), .busy_vec(bv_bp), .dbg_out(dbg_bp)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .DBG_IDX(DBG_IDX)) dut_nb (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_nb), .rd_busy(rdb_nb),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .issue_vld(issue_vld), .issue_dst(issue_dst), .busy_vec(bv_nb), .dbg_out(dbg_nb)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model update: reset wipes everything, otherwise apply writes and issues of this edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mMem[i] <= '0;
            mBusy <= '0;
        end else begin
            if (we0 && wa0 != 0) mMem[wa0] <= wd0;
            if (we1 && wa1 != 0 && !(we0 && wa0 == wa1)) mMem[wa1] <= wd1;
            for (int i = 1; i < NREGS; i++) begin
                if (issue_vld && issue_dst == i) mBusy[i] <= 1'b1;
                else if ((we0 && wa0 == i) || (we1 && wa1 == i)) mBusy[i] <= 1'b0;
            end
        end
    end

    function automatic logic [XLEN-1:0] expRd(int k, bit byp);
        logic [AW-1:0] a;
        a = ra[k*AW +: AW];
        if (a == 0 || rst) return '0;
        if (byp && we0 && wa0 == a) return wd0;
        if (byp && we1 && wa1 == a) return wd1;
        return mMem[a];
    endfunction

    function automatic logic expBusy(int k, bit byp);
        logic [AW-1:0] a;
        a = ra[k*AW +: AW];
        if (a == 0 || rst) return 1'b0;
        if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < NRD; k++) begin
            checkValue($sformatf("rd_bp[%0d]", k), rd_bp[k*XLEN +: XLEN], expRd(k, 1'b1));
            checkValue($sformatf("rd_nb[%0d]", k), rd_nb[k*XLEN +: XLEN], expRd(k, 1'b0));
            checkValue($sformatf("rd_busy_bp[%0d]", k), 32'(rdb_bp[k]), 32'(expBusy(k, 1'b1)));
            checkValue($sformatf("rd_busy_nb[%0d]", k), 32'(rdb_nb[k]), 32'(expBusy(k, 1'b0)));
        end
        checkValue("busy_vec_bp", 32'(bv_bp), 32'(mBusy));
        checkValue("busy_vec_nb", 32'(bv_nb), 32'(mBusy));
        checkValue("dbg_bp", dbg_bp, mMem[DBG_IDX]);
        checkValue("dbg_nb", dbg_nb, mMem[DBG_IDX]);
    endtask

    // Compare process: every mid-cycle point the outputs must match the model
    always @(negedge clk) checkOutput();

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        issue_vld = 0; issue_dst = '0;
        ra = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        ra  = NRD*AW'($urandom_range(0, (1 << (NRD*AW)) - 1));
        we0 = 1'($urandom_range(0, 1));
        wa0 = AW'($urandom_range(0, NREGS-1));
        wd0 = $urandom;
        we1 = 1'($urandom_range(0, 1));
        wa1 = AW'($urandom_range(0, NREGS-1));
        if ($urandom_range(0, 3) == 0) wa1 = wa0;
        wd1 = $urandom;
        issue_vld = ($urandom_range(0, 2) != 0);
        issue_dst = AW'($urandom_range(0, NREGS-1));
        if ($urandom_range(0, 3) == 0) issue_dst = wa0;
        if ($urandom_range(0, 2) == 0) ra[0 +: AW] = wa0;
        if ($urandom_range(0, 2) == 0) ra[AW +: AW] = wa1;
        rst = ($urandom_range(0, 999) == 0);
        tick();
    endtask

    // Directed scenarios with literal expectations, then the randomized run
    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkValue("reset rd0", rd_bp[0 +: XLEN], 32'h0);
        checkValue("reset busy_vec", 32'(bv_bp), 32'h0);
        checkValue("reset dbg", dbg_nb, 32'h0);

        // Write r3, read on two ports; write to r0 is dropped
        we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF;
        tick();
        idle(); ra[0 +: AW] = 3; ra[AW +: AW] = 3;
        @(negedge clk);
        checkValue("r3 port0", rd_nb[0 +: XLEN], 32'hDEADBEEF);
        checkValue("r3 port1", rd_bp[XLEN +: XLEN], 32'hDEADBEEF);
        tick();
        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
        tick();
        idle();
        @(negedge clk);
        checkValue("r0 zero", rd_bp[0 +: XLEN], 32'h0);

        // Forwarding of a late-return write on port 1
        tick();
        we1 = 1; wa1 = 7; wd1 = 32'hA5; ra[AW +: AW] = 7;
        @(negedge clk);
        checkValue("bypass rd1", rd_bp[XLEN +: XLEN], 32'hA5);
        checkValue("bypass busy1", 32'(rdb_bp[1]), 32'h0);
        checkValue("nobypass rd1 old", rd_nb[XLEN +: XLEN], 32'h0);
        tick();
        idle(); ra[AW +: AW] = 7;
        @(negedge clk);
        checkValue("nobypass rd1 new", rd_nb[XLEN +: XLEN], 32'hA5);

        // Same-address collision: port 0 wins
        tick();
        we0 = 1; wa0 = 9; wd0 = 1; we1 = 1; wa1 = 9; wd1 = 2;
        tick();
        idle(); ra[0 +: AW] = 9;
        @(negedge clk);
        checkValue("collision r9", rd_nb[0 +: XLEN], 32'h1);

        // Scoreboard: issue, issue-with-retire, late retire
        tick();
        issue_vld = 1; issue_dst = 4;
        tick();
        idle(); ra[0 +: AW] = 4;
        @(negedge clk);
        checkValue("busy4 set", 32'(bv_nb[4]), 32'h1);
        checkValue("rd_busy r4", 32'(rdb_bp[0]), 32'h1);
        tick();
        issue_vld = 1; issue_dst = 4; we0 = 1; wa0 = 4; wd0 = 32'h44; ra[0 +: AW] = 4;
        @(negedge clk);
        checkValue("fwd clears rd_busy", 32'(rdb_bp[0]), 32'h0);
        tick();
        idle();
        @(negedge clk);
        checkValue("busy4 held", 32'(bv_bp[4]), 32'h1);
        tick();
        we1 = 1; wa1 = 4; wd1 = 32'h55;
        tick();
        idle(); ra[0 +: AW] = 4;
        @(negedge clk);
        checkValue("busy4 cleared", 32'(bv_bp[4]), 32'h0);
        checkValue("r4 late data", rd_nb[0 +: XLEN], 32'h55);

        // Mid-operation reset discards concurrent write and issue
        tick();
        we0 = 1; wa0 = 5; wd0 = 32'h1234;
        tick();
        idle(); ra[0 +: AW] = 5;
        @(negedge clk);
        checkValue("dbg r5", dbg_bp, 32'h1234);
        #1;
        rst = 1; we0 = 1; wa0 = 6; wd0 = 32'h5555; issue_vld = 1; issue_dst = 6;
        #1;
        checkValue("reset rd r5", rd_nb[0 +: XLEN], 32'h0);
        checkValue("reset dbg r5", dbg_nb, 32'h0);
        checkValue("reset busy_vec mid", 32'(bv_nb), 32'h0);
        tick();
        rst = 0;
        idle(); ra[0 +: AW] = 6;
        @(negedge clk);
        checkValue("r6 discarded", rd_bp[0 +: XLEN], 32'h0);
        checkValue("issue discarded", 32'(bv_bp), 32'h0);
        tick();

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < NRAND; n++) applyStimulus();
        rst = 0;
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
